// File: rtl/j1_irq_ctrl.sv
// -----------------------------------------------------------------------------
// j1_irq_ctrl
//
// Interrupt controller for the J1 core. Up to NSRC external event lines are
// synchronized, edge-detected and latched into pending bits. A small request
// FSM raises a one-cycle interrupt_request pulse towards the J1 whenever the
// global enable is set and an enabled source is pending, then waits for the
// handler to claim it through the IO bus.
//
// Register map (offset from BASE_ADDR):
//   +0 PENDING  read pending bits, write-1-to-clear
//   +1 ENABLE   read/write per-source enable
//   +2 CLAIM    read only: {1'b1, 11'b0, idx} of the lowest pending&enabled
//               source (and clears it), or 16'h0000 when nothing is pending
//   +3 GIE      bit0 = global interrupt enable
//
// Ports:
//   clk               system clock, shared with the J1
//   reset             asynchronous, active-high reset
//   io_rd, io_wr      J1 IO read / write strobes (one cycle each)
//   io_addr           J1 IO address
//   io_dout           J1 write data
//   irq_rdata         registered read data, valid the cycle after io_rd,
//                     held until the next mapped read
//   irq_src           asynchronous interrupt source lines
//   interrupt_request one-cycle request pulse to the J1
//
// Build option:
//   J1_IRQ_LEVEL_EN   when defined, sources are level-sensitive: the edge
//                     detector is removed and a pending bit is re-set every
//                     cycle its synchronized source is high.
// -----------------------------------------------------------------------------
module j1_irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0040
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [15:0]     io_addr,
    input  logic [15:0]     io_dout,
    output logic [15:0]     irq_rdata,
    input  logic [NSRC-1:0] irq_src,
    output logic            interrupt_request
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_GIE     = 2'd3;

    state_t          state, state_nxt;
    logic [NSRC-1:0] pending, enable;
    logic            gie;
    logic [NSRC-1:0] sync1, sync2;
    logic [NSRC-1:0] src_set;

    // ------------------------------------------------------------------
    // Address decode. The offset subtraction wraps, so anything below
    // BASE_ADDR lands far above 3 and is treated as unmapped.
    // ------------------------------------------------------------------
    logic [15:0] offset;
    logic        mapped, rd_hit, wr_hit, claim_rd;
    logic [1:0]  reg_sel;

    assign offset   = io_addr - BASE_ADDR;
    assign mapped   = (offset[15:2] == 14'd0);
    assign reg_sel  = offset[1:0];
    assign rd_hit   = io_rd && mapped;
    assign wr_hit   = io_wr && mapped;
    assign claim_rd = rd_hit && (reg_sel == REG_CLAIM);

    // Data bits above the source count have no register behind them.
    logic unused_dout;
    assign unused_dout = ^io_dout[15:NSRC];

    // ------------------------------------------------------------------
    // Source path: two-flop synchronizer, then (edge mode) a third flop
    // to detect the synchronized rising edge.
    // ------------------------------------------------------------------
    // NOTE: every clocked register uses non-blocking assignment so all
    // flops sample pre-edge values; blocking here would collapse the
    // synchronizer stages into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end

`ifdef J1_IRQ_LEVEL_EN
    assign src_set = sync2;
`else
    logic [NSRC-1:0] sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync3 <= '0;
        else       sync3 <= sync2;
    end

    assign src_set = sync2 & ~sync3;
`endif

    // ------------------------------------------------------------------
    // Fixed-priority claim encoder: index 0 wins. Scanning from the top
    // down leaves the lowest active index as the final assignment.
    // ------------------------------------------------------------------
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] claim_onehot;
    logic [3:0]      claim_idx;
    logic            claim_found;

    assign active = pending & enable;

    // NOTE: combinational outputs get a default before any condition so
    // no path leaves them unassigned, which would infer a latch.
    always_comb begin
        claim_found  = 1'b0;
        claim_idx    = 4'd0;
        claim_onehot = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_found     = 1'b1;
                claim_idx       = 4'(i);
                claim_onehot    = '0;
                claim_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending / enable / GIE registers. A newly detected source event is
    // OR-ed in after the clears so it always survives a same-cycle W1C
    // or claim on the same bit.
    // ------------------------------------------------------------------
    logic [NSRC-1:0] w1c_clr, claim_clr, pending_nxt;

    assign w1c_clr     = (wr_hit && reg_sel == REG_PENDING) ? io_dout[NSRC-1:0] : '0;
    assign claim_clr   = (claim_rd && claim_found) ? claim_onehot : '0;
    assign pending_nxt = (pending & ~w1c_clr & ~claim_clr) | src_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            enable  <= '0;
            gie     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (wr_hit && reg_sel == REG_ENABLE) enable <= io_dout[NSRC-1:0];
            if (wr_hit && reg_sel == REG_GIE)    gie    <= io_dout[0];
        end
    end

    // ------------------------------------------------------------------
    // Read data. Built from the current (pre-write) register values, so a
    // simultaneous read and write returns what was there before the write.
    // ------------------------------------------------------------------
    logic [15:0] rdata_nxt;

    always_comb begin
        rdata_nxt = 16'h0000;
        case (reg_sel)
            REG_PENDING: rdata_nxt[NSRC-1:0] = pending;
            REG_ENABLE:  rdata_nxt[NSRC-1:0] = enable;
            REG_CLAIM:   if (claim_found) rdata_nxt = {1'b1, 11'b0, claim_idx};
            default:     rdata_nxt[0] = gie;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       irq_rdata <= 16'h0000;
        else if (rd_hit) irq_rdata <= rdata_nxt;
    end

    // ------------------------------------------------------------------
    // Request FSM. REQ lasts exactly one cycle regardless of ENABLE/GIE
    // changes; SERVICE waits for the handler's claim read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        interrupt_request = 1'b0;
        case (state)
            S_IDLE: begin
                if (gie && |active) state_nxt = S_REQ;
            end
            S_REQ: begin
                interrupt_request = 1'b1;
                state_nxt         = S_SERVICE;
            end
            S_SERVICE: begin
                if (claim_rd || !gie) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_j1_irq_ctrl
//
// Scoreboard bench for j1_irq_ctrl. A reference model, updated on every
// rising clock edge from the bus and source inputs, pushes the expected read
// data of each mapped read into a queue and tracks when a request pulse is
// due. A separate monitor on the falling edge pops the queue after each read
// and compares irq_rdata and interrupt_request every cycle. Directed
// sequences add checks against fixed constants; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_j1_irq_ctrl;

    localparam int          NSRC = 8;
    localparam logic [15:0] BASE = 16'h0040;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            io_rd = 1'b0;
    logic            io_wr = 1'b0;
    logic [15:0]     io_addr = 16'h0000;
    logic [15:0]     io_dout = 16'h0000;
    logic [15:0]     irq_rdata;
    logic [NSRC-1:0] irq_src = '0;
    logic            interrupt_request;

    j1_irq_ctrl #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
        .clk               (clk),
        .reset             (reset),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .io_addr           (io_addr),
        .io_dout           (io_dout),
        .irq_rdata         (irq_rdata),
        .irq_src           (irq_src),
        .interrupt_request (interrupt_request)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [NSRC-1:0] m_pend, m_en;
    logic            m_gie;
    logic [NSRC-1:0] h1, h2, h3;      // source samples from 1, 2, 3 edges ago
    bit              m_req;           // a request pulse is due this cycle
    bit              m_wait_claim;    // a pulse went out, handler not done yet
    logic [15:0]     rd_q[$];
    bit              rd_issued;
    logic [15:0]     exp_rdata;

    function automatic int lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_gie = 1'b0;
        h1 = '0; h2 = '0; h3 = '0;
        m_req = 0; m_wait_claim = 0;
        rd_q.delete();
        rd_issued = 0;
        exp_rdata = 16'h0000;
    endtask

    task automatic model_step();
        logic [15:0]     off, rv;
        bit              mapped, rd_hit, wr_hit, claim_rd;
        logic [NSRC-1:0] clr, set;
        int              lo;
        off      = io_addr - BASE;
        mapped   = (off < 16'd4);
        rd_hit   = io_rd && mapped;
        wr_hit   = io_wr && mapped;
        claim_rd = rd_hit && (off == 16'd2);
        lo       = lowest(m_pend & m_en);
        clr      = '0;

        if (rd_hit) begin
            case (off[1:0])
                2'd0:    rv = 16'(m_pend);
                2'd1:    rv = 16'(m_en);
                2'd2:    rv = (lo >= 0) ? (16'h8000 | 16'(lo)) : 16'h0000;
                default: rv = {15'b0, m_gie};
            endcase
            rd_q.push_back(rv);
            rd_issued = 1;
        end
        if (claim_rd && lo >= 0) clr[lo] = 1'b1;

        // Request timing from the pre-edge state.
        if (m_req) begin
            m_req        = 0;
            m_wait_claim = 1;
        end else if (m_wait_claim) begin
            if (claim_rd || !m_gie) m_wait_claim = 0;
        end else if (m_gie && (m_pend & m_en) != '0) begin
            m_req = 1;
        end

        if (wr_hit) begin
            case (off[1:0])
                2'd0:    clr   = clr | io_dout[NSRC-1:0];
                2'd1:    m_en  = io_dout[NSRC-1:0];
                2'd3:    m_gie = io_dout[0];
                default: ;
            endcase
        end

`ifdef J1_IRQ_LEVEL_EN
        set = h2;
`else
        set = h2 & ~h3;
`endif
        m_pend = (m_pend & ~clr) | set;
        h3 = h2;
        h2 = h1;
        h1 = irq_src;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            check("req", {15'b0, interrupt_request}, {15'b0, m_req});
            if (rd_issued) begin
                rd_issued = 0;
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_queue: read seen but scoreboard empty at %0t", $time);
                end else begin
                    exp_rdata = rd_q.pop_front();
                end
            end
            check("rdata", irq_rdata, exp_rdata);
        end
    end

    // ------------------------------------------------------------------
    // Bus / source driver tasks (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic io_read(input logic [1:0] off, output logic [15:0] d);
        @(negedge clk);
        io_rd   = 1'b1;
        io_addr = BASE + 16'(off);
        @(negedge clk);
        io_rd = 1'b0;
        d     = irq_rdata;
    endtask

    task automatic io_write(input logic [1:0] off, input logic [15:0] d);
        @(negedge clk);
        io_wr   = 1'b1;
        io_addr = BASE + 16'(off);
        io_dout = d;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    // Raise the masked sources for two cycles; report the falling edge
    // (counted from the raise) on which the first pulse was seen, or -1.
    task automatic pulse_src(input logic [NSRC-1:0] mask, output int lat);
        lat     = -1;
        irq_src = irq_src | mask;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) irq_src = irq_src & ~mask;
            if (interrupt_request && lat < 0) lat = k;
        end
    endtask

    task automatic wait_req(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (interrupt_request) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] d;
        int          lat;
        int          idx;
        int          r;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        for (int i = 0; i < 4; i++) begin
            io_read(2'(i), d);
            check("reset_reg", d, 16'h0000);
        end
        wait_req(20, lat);
        check("reset_no_req", 16'(lat), 16'hFFFF);

        // Single source, latency and claim.
        io_write(2'd1, 16'h00FF);
        io_write(2'd3, 16'h0001);
        pulse_src(8'h08, lat);
        check("src3_latency", 16'(lat), 16'd4);
        io_read(2'd2, d);
        check("claim_src3", d, 16'h8003);
        io_read(2'd0, d);
        check("pending_after_claim", d, 16'h0000);

        // Two sources together: priority, then re-request after claim.
        pulse_src(8'h24, lat);
        check("dual_latency", 16'(lat), 16'd4);
        io_read(2'd2, d);
        check("claim_src2", d, 16'h8002);
        wait_req(8, lat);
        check("rerequest_latency", 16'(lat), 16'd1);
        io_read(2'd2, d);
        check("claim_src5", d, 16'h8005);

        // Disabled source: latches but never requests; W1C clears.
        io_write(2'd1, 16'h0000);
        pulse_src(8'h02, lat);
        check("disabled_no_req", 16'(lat), 16'hFFFF);
        io_read(2'd0, d);
        check("pending_disabled", d, 16'h0002);
        io_write(2'd0, 16'h0002);
        io_read(2'd0, d);
        check("pending_w1c", d, 16'h0000);

        // Empty claim, then reset while in SERVICE.
        io_read(2'd2, d);
        check("claim_empty", d, 16'h0000);
        io_write(2'd1, 16'h00FF);
        pulse_src(8'h10, lat);
        check("src4_latency", 16'(lat), 16'd4);
        io_read(2'd1, d);
        check("enable_readback", d, 16'h00FF);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("reset_mid_req", {15'b0, interrupt_request}, 16'h0000);
        check("reset_mid_rdata", irq_rdata, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io_read(2'(i), d);
            check("post_reset_reg", d, 16'h0000);
        end

`ifdef J1_IRQ_LEVEL_EN
        // Level mode: a held source re-requests after claim.
        io_write(2'd1, 16'h0001);
        io_write(2'd3, 16'h0001);
        irq_src[0] = 1'b1;
        wait_req(10, lat);
        check("level_latency", 16'(lat), 16'd4);
        io_read(2'd2, d);
        check("level_claim0", d, 16'h8000);
        wait_req(10, lat);
        check("level_rerequest", 16'(lat), 16'd1);
        irq_src[0] = 1'b0;
        repeat (6) @(negedge clk);
        io_read(2'd2, d);
        check("level_claim_final", d, 16'h8000);
        wait_req(10, lat);
        check("level_no_req", 16'(lat), 16'hFFFF);
`endif

        // Randomized phase, checked by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            io_rd   = 1'b0;
            io_wr   = 1'b0;
            io_dout = 16'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                idx          = $urandom_range(0, NSRC - 1);
                irq_src[idx] = ~irq_src[idx];
            end
            r = $urandom_range(0, 11);
            case (r)
                4, 5: begin
                    io_rd = 1'b1;
                    if ($urandom_range(0, 7) == 0) io_addr = BASE - 16'd1;
                    else                           io_addr = BASE + 16'($urandom_range(0, 5));
                end
                6, 7: begin
                    io_rd   = 1'b1;
                    io_addr = BASE + 16'd2;
                end
                8: begin
                    io_wr   = 1'b1;
                    io_addr = BASE;
                end
                9: begin
                    io_wr   = 1'b1;
                    io_addr = BASE + 16'd1;
                end
                10: begin
                    io_wr   = 1'b1;
                    io_addr = BASE + 16'd3;
                    io_dout = {15'b0, 1'($urandom_range(0, 3) != 0)};
                end
                11: begin
                    io_rd   = 1'b1;
                    io_wr   = 1'b1;
                    io_addr = BASE + 16'($urandom_range(0, 3));
                end
                default: ;
            endcase
        end
        @(negedge clk);
        io_rd = 1'b0;
        io_wr = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/j1_irq_ctrl.md
# j1_irq_ctrl

Interrupt controller for the J1 core. It collects up to NSRC external interrupt sources and latches them into pending bits. It raises the core's `interrupt_request` input and exposes pending, enable, claim and global-enable registers on the J1 IO bus. It sits between peripheral event lines and the J1, and is decoded from the J1 `io_*` strobes alongside other IO peripherals.

## Interface
- `NSRC`, 8: number of interrupt sources, 1..15.
- `BASE_ADDR`, 16'h0040: IO address of register 0. Registers occupy BASE_ADDR..BASE_ADDR+3.
- `clk` in 1: system clock, shared with J1.
- `reset` in 1: asynchronous, active-high reset.
- `io_rd` in 1: J1 IO read strobe, one cycle.
- `io_wr` in 1: J1 IO write strobe, one cycle.
- `io_addr` in 16: J1 IO address.
- `io_dout` in 16: J1 write data.
- `irq_rdata` out 16: registered read data. The top level muxes it into J1 `io_din`.
- `irq_src` in NSRC: asynchronous interrupt source lines.
- `interrupt_request` out 1: one-cycle request pulse to J1.

## Operation
- Register map (offset from BASE_ADDR):
  - +0 PENDING: reads pending[NSRC-1:0]; a write clears the pending bits where the data bit is 1 (W1C).
  - +1 ENABLE: read/write enable[NSRC-1:0].
  - +2 CLAIM: read only. Returns {1'b1, 11'b0, idx[3:0]} for the lowest-index pending&enable bit, and clears that pending bit. Returns 16'h0000 with no state change if none is pending.
  - +3 GIE: bit0 is the global interrupt enable, read/write.
  - Writes to CLAIM and all unmapped bits are ignored; unmapped bits read 0.
- Source path:
  - Each irq_src bit passes through a 2-flop synchronizer, then a rising-edge detector (third flop).
  - A detected edge sets pending[i].
  - Set beats a same-cycle W1C or claim-clear on the same bit.
- Priority: fixed; index 0 is highest.
- Request FSM:
  - IDLE: goes to REQ when GIE & |(pending & enable).
  - REQ: interrupt_request=1 for exactly one cycle, then SERVICE.
  - SERVICE: waits for a CLAIM read (io_rd at BASE+2), then IDLE. GIE cleared in SERVICE also returns to IDLE.
- After returning to IDLE, the controller re-requests on the next cycle if other enabled bits are still pending.
- Changes to ENABLE/GIE during REQ do not truncate the pulse.
- Reset: pending, enable, GIE, synchronizer/edge flops, irq_rdata and interrupt_request all go to 0; FSM goes to IDLE. Reset asserted mid-SERVICE drops everything with no request pulse.

## Timing
- Reads: irq_rdata is registered on the clk edge that samples io_rd at a mapped address. It is valid the following cycle and held until the next mapped read.
- The CLAIM-clear of the pending bit occurs on that same edge.
- Writes take effect on the edge that samples io_wr; the new value is readable by a read issued the next cycle.
- irq_src latency:
  - The source is high at sampling edge E.
  - pending set at edge E+2.
  - FSM enters REQ at E+3; interrupt_request high during the cycle after E+3.
- Minimum spacing between request pulses: 3 cycles (REQ, SERVICE with immediate claim, IDLE).
- An io_rd and io_wr in the same cycle is illegal for J1; if it occurs, the write is performed and the read returns the pre-write value.

## Configuration
- `J1_IRQ_LEVEL_EN`:
  - Defined: sources are level-sensitive and the edge detector is omitted. pending[i] is set every cycle the synchronized source is high, so W1C and CLAIM clear the bit only if the source has dropped.
  - Undefined (default): rising-edge latching as described above.

## Test plan
- Reset, then read +0..+3 -> all return 16'h0000; interrupt_request stays 0 for 20 cycles.
- ENABLE=16'h00FF, GIE=1, pulse irq_src[3] -> interrupt_request one-cycle pulse 4 cycles after the edge; CLAIM reads 16'h8003; PENDING then reads 16'h0000.
- irq_src[5] and irq_src[2] rise together -> a single pulse; CLAIM returns 16'h8002; the next IDLE yields a second pulse; CLAIM returns 16'h8005.
- ENABLE=0, pulse irq_src[1] -> no request; PENDING reads 16'h0002; write 16'h0002 to +0 -> PENDING reads 16'h0000.
- CLAIM with nothing pending -> 16'h0000, FSM stays IDLE. Assert reset while in SERVICE -> interrupt_request 0 and all registers 0 in the same cycle.
- With `J1_IRQ_LEVEL_EN`: hold irq_src[0] high, then claim -> pending[0] re-sets and a new pulse follows; after the source is released and claimed, no further pulse.
